// File: rtl/div_unit.sv
// Signed restoring divider producing {remainder, quotient}, truncating toward zero.
// Latency: op_done rises WIDTH+1 clk edges after the edge that samples op_start.
// Backpressure: none; one operation at a time, op_start ignored outside INIT, op_clear acknowledges/aborts.
//
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   op_start, op_clear    - start request (INIT only), synchronous abort/acknowledge
//   dividend, divisor     - signed WIDTH-bit operands, captured when op_start is accepted
//   op_done, result       - result valid flag, {remainder, quotient} (zero while not done)
//   div_by_zero           - divisor was zero, valid while op_done=1
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 op_start,
    input  logic                 op_clear,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 op_done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        INIT      = 2'b00,
        START     = 2'b01,
        CALCULATE = 2'b10,
        DONE      = 2'b11
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_dvd;      // operands exactly as captured
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_div;      // |divisor|
    logic [WIDTH-1:0]   r_rem;      // partial remainder
    logic [WIDTH-1:0]   r_quo;      // quotient / dividend shift register
    logic [CW-1:0]      r_cnt;
    logic               r_sign_q;
    logic               r_sign_r;
    logic               r_done;
    logic               r_dbz;
    logic [2*WIDTH-1:0] r_result;

    logic [WIDTH-1:0]   w_dvd_abs;
    logic [WIDTH-1:0]   w_dvs_abs;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_rem_step;
    logic [WIDTH-1:0]   w_quo_step;
    logic               w_dbz;
    logic [WIDTH-1:0]   w_quo_fin;
    logic [WIDTH-1:0]   w_rem_fin;
    logic               w_last;

    // Magnitudes are plain unsigned WIDTH-bit values, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
    assign w_dvd_abs = r_dvd[WIDTH-1] ? (~r_dvd + 1'b1) : r_dvd;
    assign w_dvs_abs = r_dvs[WIDTH-1] ? (~r_dvs + 1'b1) : r_dvs;

    // One restoring step: shift {rem, quo} left, trial-subtract with a spare bit for the sign.
    assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_div};
    assign w_rem_step = w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quo_step = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};

    // The final step's outcome is sign-corrected and registered on the same edge as DONE entry.
    assign w_dbz     = (r_dvs == '0);
    assign w_quo_fin = w_dbz ? '1    : (r_sign_q ? (~w_quo_step + 1'b1) : w_quo_step);
    assign w_rem_fin = w_dbz ? r_dvd : (r_sign_r ? (~w_rem_step + 1'b1) : w_rem_step);
    assign w_last    = (r_state == CALCULATE) && (r_cnt == CW'(1));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; op_clear outranks everything else
    always_comb begin
        w_state_next = r_state;
        if (op_clear) begin
            w_state_next = INIT;
        end else begin
            case (r_state)
                INIT:      if (op_start) w_state_next = START;
                START:     w_state_next = CALCULATE;
                CALCULATE: if (r_cnt == CW'(1)) w_state_next = DONE;
                DONE:      w_state_next = DONE;
                default:   w_state_next = INIT;
            endcase
        end
    end

    // Outputs come straight from registers; r_result is only ever written with the final value.
    always_comb begin
        op_done     = r_done;
        div_by_zero = r_dbz;
        result      = r_result;
    end

    // Datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_div    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_result <= '0;
        end else if (op_clear) begin
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_div    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                INIT: begin
                    if (op_start) begin
                        r_dvd <= dividend;
                        r_dvs <= divisor;
                    end
                end
                START: begin
                    r_quo    <= w_dvd_abs;
                    r_rem    <= '0;
                    r_div    <= w_dvs_abs;
                    r_cnt    <= CW'(WIDTH);
                    r_sign_q <= r_dvd[WIDTH-1] ^ r_dvs[WIDTH-1];
                    r_sign_r <= r_dvd[WIDTH-1];
                end
                CALCULATE: begin
                    r_rem <= w_rem_step;
                    r_quo <= w_quo_step;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_result <= {w_rem_fin, w_quo_fin};
                        r_done   <= 1'b1;
                        r_dbz    <= w_dbz;
                    end
                end
                default: ;  // DONE holds everything
            endcase
        end
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand width; result width is 2*WIDTH.
REQ-002 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 reset_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 op_start  input  1  SHALL request a new division; it is sampled only in INIT.
REQ-005 op_clear  input  1  SHALL be a synchronous abort/acknowledge that returns the block to INIT.
REQ-006 dividend  input  WIDTH  SHALL be the signed two's-complement dividend.
REQ-007 divisor  input  WIDTH  SHALL be the signed two's-complement divisor.
REQ-008 op_done  output  1  SHALL be a registered flag meaning the result is valid.
REQ-009 result  output  2*WIDTH  SHALL carry {remainder, quotient}, with the quotient in the low WIDTH bits.
REQ-010 div_by_zero  output  1  SHALL be a registered flag, valid while op_done=1, meaning the divisor was 0.

Function
REQ-011 States SHALL be INIT=2'b00, START=2'b01, CALCULATE=2'b10, DONE=2'b11.
REQ-012 INIT SHALL go to START on an edge with op_start=1; otherwise it stays in INIT.
REQ-013 START SHALL go to CALCULATE unconditionally.
REQ-014 CALCULATE SHALL go to DONE on the edge where the iteration counter equals 1.
REQ-015 DONE SHALL hold until op_clear or reset.
REQ-016 dividend and divisor SHALL be captured on the INIT edge where op_start=1; later input changes have no effect on the operation in flight.
REQ-017 In START the block SHALL:
- load |dividend| into the quotient/shift register;
- clear the partial remainder to 0;
- load |divisor|;
- set the counter to WIDTH;
- latch sign_q = dividend[MSB]^divisor[MSB] and sign_r = dividend[MSB].
REQ-018 Each CALCULATE cycle SHALL perform one unsigned restoring step:
- shift {remainder, quotient} left by 1;
- trial-subtract the divisor from the remainder (WIDTH+1-bit arithmetic);
- if the difference is non-negative, keep it and set quotient LSB=1; otherwise restore and set quotient LSB=0;
- decrement the counter by 1.
REQ-019 Division SHALL truncate toward zero:
- final quotient is negated when sign_q=1;
- final remainder is negated when sign_r=1.
REQ-020 The magnitude of the most negative value (2^(WIDTH-1)) SHALL be handled as unsigned WIDTH-bit; -2^(WIDTH-1) / -1 SHALL yield quotient 2^(WIDTH-1) (bit pattern 0x80000000 for WIDTH=32) and remainder 0, with no flag.
REQ-021 Divisor = 0 SHALL still take the full latency; at completion it SHALL force quotient all-ones, remainder = original dividend, and div_by_zero=1.
REQ-022 op_done SHALL rise on the same edge the state enters DONE, exactly WIDTH+1 edges after the op_start sampling edge (33 for WIDTH=32).
REQ-023 op_done SHALL stay high in DONE.
REQ-024 result SHALL read 0 whenever op_done=0; intermediate values are never visible.
REQ-025 op_start SHALL be ignored in START, CALCULATE and DONE.
REQ-026 op_clear=1 on any edge SHALL set state=INIT, op_done=0 and div_by_zero=0, and clear the internal registers.
REQ-027 op_clear SHALL have priority over op_start on the same edge; no operation starts on that edge.
REQ-028 A new op_start SHALL be accepted on the first edge after returning to INIT.

Reset
REQ-029 reset_n=0 SHALL immediately, independent of clk, force state=INIT, op_done=0, div_by_zero=0, result=0, counter=0 and all internal registers to 0.
REQ-030 Reset asserted mid-CALCULATE SHALL discard the operation; no op_done pulse follows.
REQ-031 After reset_n deasserts, the block SHALL behave as freshly in INIT.

Verification
REQ-032 100 / 7 -> result=0x00000002_0000000E, div_by_zero=0; op_done rises 33 edges after op_start is sampled.
REQ-033 -100 / 7 -> result=0xFFFFFFFE_FFFFFFF2; 100 / -7 -> result=0x00000002_FFFFFFF2.
REQ-034 0x80000000 / 0xFFFFFFFF -> result=0x00000000_80000000, div_by_zero=0.
REQ-035 5 / 0 -> result=0x00000005_FFFFFFFF, div_by_zero=1, after the same 33-edge latency.
REQ-036 op_clear pulse 10 edges into CALCULATE -> next edge state=INIT, op_done=0, result=0; then 9 / 3 -> result=0x00000000_00000003.
REQ-037 reset_n low 5 edges into CALCULATE -> all outputs 0 asynchronously, no op_done afterward; op_start held high during DONE leaves the result unchanged.
